// File: rtl/ram_b_arb_pkg.sv
// Shared types and defaults for the RAM_B two-port round-robin arbiter.
// Optional init sweep is enabled by defining RAM_B_ARB_INIT_EN.
package ram_b_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH      = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Identifies which port the round-robin pointer currently favours.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/ram_b_arbiter_rr_arb2.sv
// Two-way round-robin picker: the pointer names the port that wins a tie.
// Purely combinational; the caller owns the pointer register.
module rr_arb2
  import ram_b_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1,
  output logic ptr_nxt
);

  // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0    = req0 & (~req1 | (ptr == PORT0));
    gnt1    = req1 & (~req0 | (ptr == PORT1));
    ptr_nxt = ptr;
    if (gnt0) begin
      ptr_nxt = PORT1;
    end else if (gnt1) begin
      ptr_nxt = PORT0;
    end
  end

endmodule

// File: rtl/ram_b_arbiter.sv
// Round-robin arbiter sharing single-port RAM_B between two masters.
// Define RAM_B_ARB_INIT_EN to clear the whole RAM to INIT_VAL after reset.
module ram_b_arbiter
  import ram_b_arb_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ready,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  logic              run_en;
  logic              in_init;
  logic [ADDR_W-1:0] init_addr;
  logic              ptr_q;
  logic              ptr_nxt;
  logic              rvalid0_q;
  logic              rvalid1_q;

`ifdef RAM_B_ARB_INIT_EN
  state_t            state_q;
  logic [ADDR_W-1:0] init_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_q <= RUN;
      end
    end
  end

  assign in_init   = rst_n && (state_q == INIT);
  assign run_en    = rst_n && (state_q == RUN);
  assign ready     = rst_n && (state_q == RUN);
  assign init_addr = init_cnt_q;
`else
  assign in_init   = 1'b0;
  assign run_en    = rst_n;
  assign ready     = 1'b1;
  assign init_addr = '0;
`endif

  // Requests are masked outside RUN so they are ignored rather than queued.
  rr_arb2 u_rr_arb2 (
    .req0    (req0 & run_en),
    .req1    (req1 & run_en),
    .ptr     (ptr_q),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .ptr_nxt (ptr_nxt)
  );

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      ptr_q     <= PORT0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      if (gnt0 | gnt1) begin
        ptr_q <= ptr_nxt;
      end
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

  // A read strobe already in flight is suppressed while reset is held.
  assign rvalid0 = rvalid0_q & rst_n;
  assign rvalid1 = rvalid1_q & rst_n;
  assign rdata0  = rvalid0 ? ram_douta : '0;
  assign rdata1  = rvalid1 ? ram_douta : '0;

  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (in_init) begin
      ram_wea   = 1'b1;
      ram_addra = init_addr;
      ram_dina  = INIT_VAL;
    end else if (gnt0) begin
      ram_wea   = we0;
      ram_addra = addr0;
      ram_dina  = wdata0;
    end else if (gnt1) begin
      ram_wea   = we1;
      ram_addra = addr1;
      ram_dina  = wdata1;
    end
  end

endmodule

// File: tb/tb_ram_b_arbiter.sv
// Self-checking bench for ram_b_arbiter with a behavioural RAM_B and a reference model.
// Covers both builds; define RAM_B_ARB_INIT_EN to exercise the init sweep.
module tb_ram_b_arbiter;

  localparam int                AW       = 6;
  localparam int                DW       = 32;
  localparam logic [DW-1:0]     INIT_VAL = '0;

  logic          clka = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ready;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, ram_douta;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clka = ~clka;

  ram_b_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(INIT_VAL)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ready     (ready),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta)
  );

  // Behavioural RAM_B: one-cycle registered read, power-up contents are a known pattern.
  logic [DW-1:0] ram [64];
  always @(posedge clka) begin
    if (ram_wea) ram[ram_addra] <= ram_dina;
    ram_douta <= ram[ram_addra];
  end

  // Reference model: memory image, who was granted last, pending read results.
  logic [DW-1:0] mdl_mem [64];
  int            last_g;
  logic          exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd0, exp_rd1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One RUN cycle: apply inputs, check against the model mid-cycle, then advance the model.
  task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output int gv);
    int            g;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clka);
    if (r0 && r1)  g = (last_g == 0) ? 1 : 0;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           g = -1;
    ew = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin ew = w0; ea = a0; ed = d0; end
    if (g == 1) begin ew = w1; ea = a1; ed = d1; end
    chk("ready",   {31'b0, ready},   32'd1);
    chk("gnt0",    {31'b0, gnt0},    {31'b0, g == 0});
    chk("gnt1",    {31'b0, gnt1},    {31'b0, g == 1});
    chk("ram_wea", {31'b0, ram_wea}, {31'b0, ew});
    chk("ram_addra", {26'b0, ram_addra}, {26'b0, ea});
    chk("ram_dina", ram_dina, ed);
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, exp_rv0});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, exp_rv1});
    chk("rdata0",  rdata0, exp_rv0 ? exp_rd0 : '0);
    chk("rdata1",  rdata1, exp_rv1 ? exp_rd1 : '0);
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (g >= 0) begin
      last_g = g;
      if (ew) mdl_mem[ea] = ed;
      else if (g == 0) begin exp_rv0 = 1'b1; exp_rd0 = mdl_mem[ea]; end
      else begin exp_rv1 = 1'b1; exp_rd1 = mdl_mem[ea]; end
    end
    gv = g;
    @(posedge clka); #1;
  endtask

  task automatic idle();
    int gv;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, gv);
  endtask

  // Hold reset for n cycles with requests asserted, then release (and sweep when enabled).
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
    addr0 = 6'd9; addr1 = 6'd10; wdata0 = 32'h1234; wdata1 = 32'h5678;
    for (int i = 0; i < n; i++) begin
      @(negedge clka);
      chk("rst gnt0",    {31'b0, gnt0},    32'd0);
      chk("rst gnt1",    {31'b0, gnt1},    32'd0);
      chk("rst rvalid0", {31'b0, rvalid0}, 32'd0);
      chk("rst rvalid1", {31'b0, rvalid1}, 32'd0);
      chk("rst rdata0",  rdata0, '0);
      chk("rst rdata1",  rdata1, '0);
      chk("rst ram_wea", {31'b0, ram_wea}, 32'd0);
      chk("rst ram_addra", {26'b0, ram_addra}, 32'd0);
      chk("rst ram_dina", ram_dina, '0);
`ifdef RAM_B_ARB_INIT_EN
      chk("rst ready", {31'b0, ready}, 32'd0);
`else
      chk("rst ready", {31'b0, ready}, 32'd1);
`endif
      @(posedge clka); #1;
    end
    rst_n   = 1'b1;
    last_g  = 1;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
`ifdef RAM_B_ARB_INIT_EN
    for (int k = 0; k < 64; k++) begin
      @(negedge clka);
      chk("init ready", {31'b0, ready},   32'd0);
      chk("init gnt0",  {31'b0, gnt0},    32'd0);
      chk("init gnt1",  {31'b0, gnt1},    32'd0);
      chk("init wea",   {31'b0, ram_wea}, 32'd1);
      chk("init addr",  {26'b0, ram_addra}, k);
      chk("init din",   ram_dina, INIT_VAL);
      @(posedge clka); #1;
    end
    for (int k = 0; k < 64; k++) mdl_mem[k] = INIT_VAL;
`endif
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    int            gv;
    int            gseq [4];
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    for (int k = 0; k < 64; k++) begin
      ram[k]     = 32'hA5A5_0000 | k;
      mdl_mem[k] = 32'hA5A5_0000 | k;
    end
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    last_g = 1; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    @(posedge clka); #1;

    do_reset(2);

    // Read address 5 straight after reset (cleared value when the sweep is built in).
    cycle(1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0, gv);
    idle();

    // Single port: writes 0x3..0xA to addr 1..8, then reads them back.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, AW'(i), DW'(i + 2), 1'b0, 1'b0, '0, '0, gv);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, gv);
    idle();
    chk("mdl addr8 readback", mdl_mem[8], 32'hA);

    // Port 1 touches the RAM once so port 0 wins the first tie.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd8, '0, gv);

    // Contention: both ports hold read requests for four cycles.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b0, 6'd3, '0, gv);
      gseq[i] = gv;
    end
    idle();
    chk("contend g0", gseq[0], 32'd0);
    chk("contend g1", gseq[1], 32'd1);
    chk("contend g2", gseq[2], 32'd0);
    chk("contend g3", gseq[3], 32'd1);

    // Cross-port write then read of the same address on the next cycle.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd7, 32'hDEAD, gv);
    cycle(1'b1, 1'b0, 6'd7, '0, 1'b0, 1'b0, '0, '0, gv);
    chk("rdata0 dead", rdata0, 32'hDEAD);
    idle();

    // Reset right after a read grant: strobe dropped, pointer back to port 0.
    cycle(1'b1, 1'b0, 6'd1, '0, 1'b0, 1'b0, '0, '0, gv);
    do_reset(1);
    cycle(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b0, 6'd2, '0, gv);
    chk("post-reset first tie", gv, 32'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd2, '0, gv);
`ifdef RAM_B_ARB_INIT_EN
    chk("addr1 after reset", exp_rd0, INIT_VAL);
`else
    chk("addr1 after reset", exp_rd0, 32'h3);
`endif
    idle();

    // Random traffic; a request that loses is held with identical fields.
    r0 = 1'b0; r1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!r0) begin
        r0 = ($urandom_range(0, 3) != 0);
        w0 = $urandom_range(0, 1) == 1;
        a0 = AW'($urandom_range(0, 63));
        d0 = $urandom;
      end
      if (!r1) begin
        r1 = ($urandom_range(0, 3) != 0);
        w1 = $urandom_range(0, 1) == 1;
        a1 = AW'($urandom_range(0, 63));
        d1 = $urandom;
      end
      cycle(r0, w0, a0, d0, r1, w1, a1, d1, gv);
      if (gv == 0) r0 = 1'b0;
      if (gv == 1) r1 = 1'b0;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
